// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: hands unique 256-bit search nonces to NUM_CORES hash
// cores by round-robin, advancing the shared nonce by one per grant.
// Ports: clk, rst (sync, high); load_i/load_nonce_i, start_i, stop_i
// host controls; req_i per-core requests; grant_o/nonce_o/nonce_valid_o
// delivery; busy_o (RUN), wrap_o (sticky wrap), issued_count_o (saturating).

module nonce_inc #(
  parameter int NB = 32
) (
  input  logic [8*NB-1:0] d_i,
  output logic [8*NB-1:0] q_o,
  output logic            co_o
);
  logic [NB:0] c;

  assign c[0] = 1'b1;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign {c[b+1], q_o[8*b +: 8]} =
      {1'b0, d_i[8*b +: 8]} + {8'd0, c[b]};
  end

  // carry out of the top byte means the input was all-ones
  assign co_o = c[NB];
endmodule

module nonce_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [255:0]         load_nonce_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [NUM_CORES-1:0] req_i,
  output logic [NUM_CORES-1:0] grant_o,
  output logic [255:0]         nonce_o,
  output logic                 nonce_valid_o,
  output logic                 busy_o,
  output logic                 wrap_o,
  output logic [CNT_W-1:0]     issued_count_o
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q;
  logic [255:0]         nonce_q;
  logic [255:0]         nonce_out_q;
  logic [255:0]         nonce_d;
  logic                 inc_co;
  logic [NUM_CORES-1:0] grant_q;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] pick;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [IW-1:0]        idx;
  logic                 hit;
  logic                 wrap_q;
  logic [CNT_W-1:0]     cnt_q;

  nonce_inc #(.NB(32)) u_inc (
    .d_i  (nonce_q),
    .q_o  (nonce_d),
    .co_o (inc_co)
  );

  // last-granted core sits out one cycle; search starts after ptr_q
  always_comb begin
    elig  = req_i & ~grant_q;
    pick  = '0;
    ptr_d = ptr_q;
    hit   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_CORES);
      if (!hit && elig[idx]) begin
        hit       = 1'b1;
        pick[idx] = 1'b1;
        ptr_d     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nonce_q     <= '0;
      nonce_out_q <= '0;
      grant_q     <= '0;
      ptr_q       <= IW'(NUM_CORES - 1);
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      grant_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (load_i) begin
            nonce_q <= load_nonce_i;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (start_i) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (hit) begin
            grant_q     <= pick;
            nonce_out_q <= nonce_q;
            nonce_q     <= nonce_d;
            ptr_q       <= ptr_d;
            if (cnt_q != '1)
              cnt_q <= cnt_q + CNT_W'(1);
            // wrapping stops the search so no nonce is reissued
            if (inc_co) begin
              wrap_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign nonce_o        = nonce_out_q;
  assign nonce_valid_o  = |grant_q;
  assign busy_o         = (state_q == RUN);
  assign wrap_o         = wrap_q;
  assign issued_count_o = cnt_q;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: directed scenarios with literal checks
// plus a cycle-by-cycle comparison against a behavioural model.

module tb_nonce_dispatcher;
  localparam int N  = 4;
  localparam int CW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_i = 1'b0;
  logic [255:0]   load_nonce_i = '0;
  logic           start_i = 1'b0;
  logic           stop_i = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N-1:0]   grant_o;
  logic [255:0]   nonce_o;
  logic           nonce_valid_o;
  logic           busy_o;
  logic           wrap_o;
  logic [CW-1:0]  issued_count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  nonce_dispatcher #(.NUM_CORES(N), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_i),
    .load_nonce_i   (load_nonce_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .req_i          (req_i),
    .grant_o        (grant_o),
    .nonce_o        (nonce_o),
    .nonce_valid_o  (nonce_valid_o),
    .busy_o         (busy_o),
    .wrap_o         (wrap_o),
    .issued_count_o (issued_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // behavioural model: running flag, counter value, last winner
  bit           m_run = 0;
  logic [255:0] m_nonce = '0;
  logic [255:0] m_out = '0;
  logic [N-1:0] m_gnt = '0;
  logic [N-1:0] m_prev;
  bit           m_wrap = 0;
  logic [CW-1:0] m_cnt = '0;
  int           m_last = N - 1;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_nonce = '0; m_out = '0; m_gnt = '0;
      m_wrap = 0; m_cnt = '0; m_last = N - 1;
    end else begin
      m_prev = m_gnt;
      m_gnt = '0;
      if (!m_run) begin
        if (load_i) begin
          m_nonce = load_nonce_i; m_wrap = 0; m_cnt = '0;
        end else if (start_i) m_run = 1;
      end else if (stop_i) begin
        m_run = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_i[c] && !m_prev[c]) begin
            m_gnt[c] = 1'b1;
            m_out = m_nonce;
            if (m_nonce == {256{1'b1}}) begin
              m_wrap = 1; m_run = 0;
            end
            m_nonce = m_nonce + 256'd1;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
            m_last = c;
            break;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_grant", 256'(grant_o), 256'(m_gnt));
    chk("m_nonce", nonce_o, m_out);
    chk("m_valid", 256'(nonce_valid_o), 256'(|m_gnt));
    chk("m_busy", 256'(busy_o), 256'(m_run));
    chk("m_wrap", 256'(wrap_o), 256'(m_wrap));
    chk("m_cnt", 256'(issued_count_o), 256'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] seen[$];
  bit dup;

  initial begin
    tick(); tick();
    chk("rst_grant", 256'(grant_o), 256'd0);
    chk("rst_nonce", nonce_o, 256'd0);
    chk("rst_busy", 256'(busy_o), 256'd0);
    rst = 1'b0;

    // single requester, mask cycle between grants
    load_i = 1; load_nonce_i = 256'hFF; tick(); load_i = 0;
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b0001; tick();
    chk("t1_g0", 256'(grant_o), 256'd1);
    chk("t1_n0", nonce_o, 256'hFF);
    tick();
    chk("t1_mask", 256'(nonce_valid_o), 256'd0);
    tick();
    chk("t1_n1", nonce_o, 256'h100);
    tick(); tick();
    chk("t1_n2", nonce_o, 256'h101);
    chk("t1_cnt", 256'(issued_count_o), 256'd3);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;

    // all cores requesting continuously
    rst = 1; tick(); rst = 0;
    load_i = 1; load_nonce_i = 256'h10; tick(); load_i = 0;
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b1111;
    seen.delete(); dup = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t2_g%0d", i), 256'(grant_o), 256'(4'b0001 << (i % 4)));
      chk($sformatf("t2_n%0d", i), nonce_o, 256'h10 + 256'(i));
      foreach (seen[j]) if (seen[j] == nonce_o) dup = 1;
      seen.push_back(nonce_o);
    end
    chk("t2_uniq", 256'(dup), 256'd0);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;

    // multi-byte carry ripple
    load_i = 1; load_nonce_i = 256'hFF_FFFF_FFFF; tick(); load_i = 0;
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b0001; tick();
    chk("t3_n0", nonce_o, 256'hFF_FFFF_FFFF);
    tick(); tick();
    chk("t3_n1", nonce_o, 256'h100_0000_0000);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;

    // wrap from all-ones
    load_i = 1; load_nonce_i = {256{1'b1}}; tick(); load_i = 0;
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b0100; tick();
    chk("t4_g", 256'(grant_o), 256'h4);
    chk("t4_n", nonce_o, {256{1'b1}});
    chk("t4_wrap", 256'(wrap_o), 256'd1);
    chk("t4_busy", 256'(busy_o), 256'd0);
    tick(); tick(); tick();
    chk("t4_nogrant", 256'(grant_o), 256'd0);
    start_i = 1; tick(); start_i = 0;
    tick();
    chk("t4_zero", nonce_o, 256'd0);
    chk("t4_sticky", 256'(wrap_o), 256'd1);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;

    // stop beats req; load ignored in RUN; load beats start
    load_i = 1; load_nonce_i = 256'h5000; tick(); load_i = 0;
    start_i = 1; tick(); start_i = 0;
    load_i = 1; load_nonce_i = 256'hAAAA; req_i = 4'b0001; tick();
    load_i = 0;
    chk("t5_n0", nonce_o, 256'h5000);
    req_i = 4'b1111; stop_i = 1; tick(); stop_i = 0; req_i = 0;
    chk("t5_stopg", 256'(grant_o), 256'd0);
    chk("t5_stopb", 256'(busy_o), 256'd0);
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b0010; tick();
    chk("t5_n1", nonce_o, 256'h5001);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;
    load_i = 1; start_i = 1; load_nonce_i = 256'hBBBB; tick();
    load_i = 0; start_i = 0;
    chk("t5_ldst_busy", 256'(busy_o), 256'd0);
    chk("t5_ldst_cnt", 256'(issued_count_o), 256'd0);
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b0001; tick();
    chk("t5_n2", nonce_o, 256'hBBBB);
    req_i = 0; stop_i = 1; tick(); stop_i = 0;

    // reset during a burst
    start_i = 1; tick(); start_i = 0;
    req_i = 4'b1111; tick(); tick();
    rst = 1; tick();
    chk("t6_grant", 256'(grant_o), 256'd0);
    chk("t6_nonce", nonce_o, 256'd0);
    chk("t6_busy", 256'(busy_o), 256'd0);
    chk("t6_cnt", 256'(issued_count_o), 256'd0);
    rst = 0;
    start_i = 1; tick(); start_i = 0;
    tick();
    chk("t6_ptr", 256'(grant_o), 256'd1);
    chk("t6_n", nonce_o, 256'd0);
    req_i = 0; tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
